axis_upsp_pixel_bridge: RTL and testbench

//  Upstream feeder for the upsampler's pixel-read port. Accepts source pixels on an AXI-Stream slave,

---
 rtl/sr_axis_pkg.sv | 20 ++
 rtl/axis_upsp_pixel_bridge_sync_fifo.sv | 73 +++++++
 rtl/axis_upsp_pixel_bridge.sv | 177 +++++++++++++++++
 tb/tb_axis_upsp_pixel_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_axis_pkg.sv
// ----------------------------------------------------------------------------
// sr_axis_pkg
// Shared types and helpers for the AXI-Stream to upsampler pixel bridge.
//   bridge_state_e : frame-sequencing FSM states
//   cnt_w()        : bit width needed to hold 0..n-1 (never less than 1)
// ----------------------------------------------------------------------------
package sr_axis_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bridge_state_e;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/axis_upsp_pixel_bridge_sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered read port: the entry at the head is
// loaded into rdata on the cycle a pop is accepted and held until the next pop.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     write request / data (ignored while full)
//   pop             read request (ignored while empty)
//   rdata           registered head data, 0 after reset
//   full, empty     occupancy flags
//   level           current occupancy, 0..DEPTH
// DEPTH must be a power of two, >= 2.
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rdata  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_upsp_pixel_bridge.sv
// ----------------------------------------------------------------------------
// axis_upsp_pixel_bridge
// Feeds the upsampler's pixel-read port from an AXI-Stream source. Source
// pixels are buffered in a small FIFO; each accepted upsp_ac_rd returns one
// pixel on the next cycle. One frame (SRC_IMG_WIDTH x SRC_IMG_HEIGHT beats)
// is counted per start, and frame_done pulses once the last pixel has been
// handed over.
//
// Optional feature macro: AXIS_TLAST_CHECK_EN
//   defined   -> tlast_err port present; each accepted beat must carry
//                tlast == (last column); a mismatch sets sticky tlast_err.
//   undefined -> no tlast_err port, s_axis_tlast is ignored.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    1-cycle frame start, honoured only in IDLE
//   s_axis_tvalid/tready/tdata/tlast   pixel stream slave
//   upsp_ac_rd               pixel read request
//   ac_upsp_rvalid/rdata     read response, one cycle after an accepted rd
//   fifo_level               FIFO occupancy
//   frame_done               1-cycle pulse, frame fully delivered
//   tlast_err                sticky row-framing error (feature macro only)
//
// State | meaning
// IDLE  | waiting for start, stream not accepted
// RUN   | accepting source beats for the current frame
// DRAIN | all beats received, waiting for the upsampler to read them out
// DONE  | single cycle, frame_done asserted
// ----------------------------------------------------------------------------
module axis_upsp_pixel_bridge
    import sr_axis_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int UPSP_DATA_WIDTH = 32,
    parameter int SRC_IMG_WIDTH   = 1920,
    parameter int SRC_IMG_HEIGHT  = 1080,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic                            s_axis_tlast,
    input  logic                            upsp_ac_rd,
    output logic                            ac_upsp_rvalid,
    output logic [UPSP_DATA_WIDTH-1:0]      ac_upsp_rdata,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            frame_done
`ifdef AXIS_TLAST_CHECK_EN
   ,output logic                            tlast_err
`endif
);

    localparam int PIX_TOTAL = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
    localparam int COL_W     = cnt_w(SRC_IMG_WIDTH);
    localparam int ROW_W     = cnt_w(SRC_IMG_HEIGHT);
    localparam int RD_W      = $clog2(PIX_TOTAL + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SRC_IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SRC_IMG_HEIGHT - 1);
    localparam logic [RD_W-1:0]  RD_TOTAL = RD_W'(PIX_TOTAL);

    generate
        if (UPSP_DATA_WIDTH != AXIS_DATA_WIDTH) begin : g_bad_width
            $error("UPSP_DATA_WIDTH must equal AXIS_DATA_WIDTH");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    bridge_state_e    state;
    bridge_state_e    state_nxt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             start_ok;
    logic             last_col;
    logic             last_beat;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [RD_W-1:0]  read_cnt;

    // tready looks only at the registered full flag, so a pop in the same
    // cycle does not open a slot for a push.
    assign s_axis_tready = (state == RUN) && !fifo_full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = upsp_ac_rd && !fifo_empty;
    assign start_ok      = (state == IDLE) && start;
    assign last_col      = (col == COL_LAST);
    assign last_beat     = push && last_col && (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (last_beat) state_nxt = DRAIN;
            DRAIN: if ((read_cnt == RD_TOTAL) && fifo_empty) state_nxt = DONE;
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col            <= '0;
            row            <= '0;
            read_cnt       <= '0;
            ac_upsp_rvalid <= 1'b0;
        end else begin
            ac_upsp_rvalid <= pop;
            if (start_ok) begin
                col      <= '0;
                row      <= '0;
                read_cnt <= '0;
            end else begin
                if (push) begin
                    if (last_col) begin
                        col <= '0;
                        row <= row + ROW_W'(1);
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
                if (pop && (read_cnt != RD_TOTAL)) begin
                    read_cnt <= read_cnt + RD_W'(1);
                end
            end
        end
    end

`ifdef AXIS_TLAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tlast_err <= 1'b0;
        end else if (start_ok) begin
            tlast_err <= 1'b0;
        end else if (push && (s_axis_tlast != last_col)) begin
            tlast_err <= 1'b1;
        end
    end
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
`endif

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AXIS_DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s_axis_tdata),
        .pop   (pop),
        .rdata (ac_upsp_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_axis_upsp_pixel_bridge.sv
// ----------------------------------------------------------------------------
// tb_axis_upsp_pixel_bridge
// Directed scenarios plus randomized frames for a 4x2 frame and 4-deep FIFO.
// A behavioural model (pixel queue, beat/read tallies, frame-active flag)
// predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_axis_upsp_pixel_bridge;

    localparam int W = 4;
    localparam int H = 2;
    localparam int N = W * H;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        tlast;
    logic        rd;
    logic        rvalid;
    logic [31:0] rdata;
    logic [2:0]  level;
    logic        frame_done;
`ifdef AXIS_TLAST_CHECK_EN
    logic        tlast_err;
`endif

    always #5 clk = ~clk;

    axis_upsp_pixel_bridge #(
        .AXIS_DATA_WIDTH (32),
        .UPSP_DATA_WIDTH (32),
        .SRC_IMG_WIDTH   (W),
        .SRC_IMG_HEIGHT  (H),
        .FIFO_DEPTH      (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tdata   (tdata),
        .s_axis_tlast   (tlast),
        .upsp_ac_rd     (rd),
        .ac_upsp_rvalid (rvalid),
        .ac_upsp_rdata  (rdata),
        .fifo_level     (level),
        .frame_done     (frame_done)
`ifdef AXIS_TLAST_CHECK_EN
       ,.tlast_err      (tlast_err)
`endif
    );

    int total = 0;
    int bad   = 0;

    // reference model
    logic [31:0] m_q[$];
    bit          m_in_frame;
    bit          m_accepting;
    int          m_acc;
    int          m_del;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          m_done;
    bit          m_done_next;
    bit          m_err;

    // observed event tallies
    int o_rv   = 0;
    int o_done = 0;
    int o_acc  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_in_frame  = 0;
        m_accepting = 0;
        m_acc       = 0;
        m_del       = 0;
        m_rvalid    = 0;
        m_rdata     = '0;
        m_done      = 0;
        m_done_next = 0;
        m_err       = 0;
    endtask

    task automatic check_outputs();
        bit exp_tr;
        exp_tr = m_in_frame && m_accepting && (m_q.size() < D);
        chk("tready", tready, exp_tr);
        chk("level", level, m_q.size());
        chk("rvalid", rvalid, m_rvalid);
        chk("rdata", rdata, m_rdata);
        chk("frame_done", frame_done, m_done);
`ifdef AXIS_TLAST_CHECK_EN
        chk("tlast_err", tlast_err, m_err);
`endif
        if (rvalid === 1'b1) o_rv++;
        if (frame_done === 1'b1) o_done++;
        if (tvalid && (tready === 1'b1)) o_acc++;
    endtask

    task automatic model_edge();
        bit push, pop, honour;
        if (rst) begin
            model_reset();
            return;
        end
        push   = m_in_frame && m_accepting && tvalid && (m_q.size() < D);
        pop    = rd && (m_q.size() > 0);
        honour = start && !m_in_frame;
        m_rvalid = pop;
        if (pop) m_rdata = m_q.pop_front();
        if (push) begin
            if (tlast !== ((m_acc % W) == W - 1)) m_err = 1;
            m_q.push_back(tdata);
            m_acc++;
            if (m_acc == N) m_accepting = 0;
        end
        if (pop && m_in_frame) m_del++;
        if (m_done) m_in_frame = 0;
        m_done      = m_done_next;
        m_done_next = pop && m_in_frame && (m_del == N);
        if (honour) begin
            m_in_frame  = 1;
            m_accepting = 1;
            m_acc       = 0;
            m_del       = 0;
            m_err       = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input logic [31:0] base, input bit swap);
        int i;
        i      = m_acc;
        tvalid = v;
        rd     = r;
        tdata  = base + 32'(i);
        tlast  = ((i % W) == W - 1);
        if (swap && i == 2) tlast = 1'b1;
        if (swap && i == 3) tlast = 1'b0;
    endtask

    task automatic start_frame();
        start  = 1'b1;
        tvalid = 1'b0;
        rd     = 1'b0;
        tick();
        start  = 1'b0;
    endtask

    task automatic finish_frame(input int vpct, input int rpct, input logic [31:0] base,
                                input bit swap, input string tag);
        int d0, n;
        d0 = o_done;
        n  = 0;
        while (o_done == d0 && n < 300) begin
            drive(int'($urandom_range(99, 0)) < vpct, int'($urandom_range(99, 0)) < rpct, base, swap);
            tick();
            n++;
        end
        chk({tag, "_done"}, o_done - d0, 1);
        tvalid = 1'b0;
        rd     = 1'b0;
    endtask

    initial begin
        int rv0, d0, a0, n;
        rst    = 1'b1;
        start  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tlast  = 1'b0;
        rd     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset_level", level, 0);
        chk("reset_rvalid", rvalid, 0);

        // 1: back-to-back beats, rd held high
        rv0 = o_rv;
        start_frame();
        finish_frame(100, 100, 32'h10, 0, "t1");
        chk("t1_rv_count", o_rv - rv0, 8);

        // 2: backpressure with no reads, then one read
        start_frame();
        a0 = o_acc;
        repeat (6) begin
            drive(1, 0, 32'h20, 0);
            tick();
        end
        chk("t2_acc4", o_acc - a0, 4);
        chk("t2_level4", level, 4);
        chk("t2_tready0", tready, 0);
        drive(1, 1, 32'h20, 0);
        tick();
        chk("t2_no_same_cycle_push", o_acc - a0, 4);
        drive(1, 0, 32'h20, 0);
        tick();
        chk("t2_push_next_cycle", o_acc - a0, 5);
        finish_frame(100, 100, 32'h20, 0, "t2");

        // 3: reads while empty in IDLE
        rv0 = o_rv;
        repeat (3) begin
            drive(0, 1, 32'h0, 0);
            tick();
        end
        chk("t3_no_rvalid", o_rv - rv0, 0);
        chk("t3_level0", level, 0);
        chk("t3_tready0", tready, 0);
        rd = 1'b0;

        // 4: reset after five accepted beats, then replay
        start_frame();
        a0 = o_acc;
        n  = 0;
        while ((o_acc - a0) < 5 && n < 40) begin
            drive(1, 1, 32'h40, 0);
            tick();
            n++;
        end
        chk("t4_acc5", o_acc - a0, 5);
        d0     = o_done;
        rst    = 1'b1;
        tvalid = 1'b0;
        rd     = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t4_tready0", tready, 0);
        chk("t4_level0", level, 0);
        tick();
        chk("t4_no_done", o_done - d0, 0);
        rv0 = o_rv;
        start_frame();
        finish_frame(70, 60, 32'h50, 0, "t4_replay");
        chk("t4_replay_rv", o_rv - rv0, 8);

        // 5: start during RUN is ignored
        rv0 = o_rv;
        d0  = o_done;
        start_frame();
        repeat (3) begin
            drive(1, 1, 32'h60, 0);
            tick();
        end
        start = 1'b1;
        drive(1, 1, 32'h60, 0);
        tick();
        start = 1'b0;
        finish_frame(100, 100, 32'h60, 0, "t5");
        chk("t5_rv", o_rv - rv0, 8);
        chk("t5_one_done", o_done - d0, 1);

`ifdef AXIS_TLAST_CHECK_EN
        // 6: early tlast in the first row
        rv0 = o_rv;
        start_frame();
        finish_frame(100, 100, 32'h70, 1, "t6");
        chk("t6_rv", o_rv - rv0, 8);
        chk("t6_err_set", tlast_err, 1);
        tick();
        chk("t6_err_held", tlast_err, 1);
        start_frame();
        chk("t6_err_cleared", tlast_err, 0);
        finish_frame(100, 100, 32'h78, 0, "t6_clean");
`endif

        // randomized frames
        for (int k = 0; k < 6; k++) begin
            rv0 = o_rv;
            start_frame();
            finish_frame(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                         $urandom, 0, "rnd");
            chk("rnd_rv", o_rv - rv0, 8);
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
